// File: rtl/dram_pkg.sv
// -----------------------------------------------------------------------------
// dram_pkg
// Shared definitions for the DRAM-side responder: line geometry, response
// codes, the responder state encoding and two small helpers (request error
// check and byte-strobe merge).
// -----------------------------------------------------------------------------
package dram_pkg;

    localparam int LINE_BYTES  = 64;
    localparam int LINE_BITS   = 512;
    localparam int OFFSET_BITS = 6;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_DATA = 3'd3,
        WR_WAIT = 3'd4,
        WR_RESP = 3'd5
    } dram_state_e;

    // A request is in error if it is not line aligned, addresses a line
    // beyond the backing array, or asks for more than one beat.
    function automatic logic req_error(input logic [31:0] addr,
                                       input logic [1:0]  len,
                                       input int unsigned depth);
        logic [31:0] line_idx;
        line_idx = addr >> OFFSET_BITS;
        return (addr[OFFSET_BITS-1:0] != '0) || (line_idx >= depth) || (len != 2'd0);
    endfunction

    // Byte-wise merge: strobed bytes come from new_line, the rest from old_line.
    function automatic logic [LINE_BITS-1:0] merge_line(input logic [LINE_BITS-1:0]  old_line,
                                                        input logic [LINE_BITS-1:0]  new_line,
                                                        input logic [LINE_BYTES-1:0] strb);
        logic [LINE_BITS-1:0] merged;
        merged = old_line;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_line[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/memDP.sv
// -----------------------------------------------------------------------------
// memDP
// Simple dual-port line storage: one synchronous write port and one
// synchronous read port. rd_data is registered and only changes on a cycle
// with rd_en, so it holds the last line read until the next read.
// Contents are never reset.
//
// Ports:
//   clock    in   system clock
//   wr_en    in   write enable
//   wr_addr  in   write line index
//   wr_data  in   write line data
//   rd_en    in   read enable
//   rd_addr  in   read line index
//   rd_data  out  registered read data
//
// BYPASS_EN != 0 forwards same-cycle write data to a read of the same index;
// with BYPASS_EN == 0 such a read returns the previous contents.
// -----------------------------------------------------------------------------
module memDP #(
    parameter int WIDTH     = 512,
    parameter int DEPTH     = 1024,
    parameter int BYPASS_EN = 0
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (BYPASS_EN != 0) begin : g_bypass
            always_ff @(posedge clock) begin
                if (rd_en) begin
                    rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
                end
            end
        end else begin : g_no_bypass
            always_ff @(posedge clock) begin
                if (rd_en) begin
                    rd_data <= mem[rd_addr];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/dram_axi_responder.sv
// -----------------------------------------------------------------------------
// dram_axi_responder
// Memory-side responder for the L2 DRAM channels. Accepts single-beat 64-byte
// line reads (AR/R) and writes (AW/W/B), stores lines in a memDP array and
// answers after LATENCY cycles. One transaction is in flight at a time.
//
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   ar_*                    read address channel (ar_size/ar_burst ignored)
//   r_*                     read data channel; r_last mirrors r_valid
//   aw_*                    write address channel (aw_size/aw_burst ignored)
//   w_*                     write data channel; w_last ignored
//   b_*                     write response channel
//   dbg_state               current FSM state (dram_state_e encoding)
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. A source raising valid keeps it and its payload stable until
// that edge; this responder holds r_valid/r_data/r_resp and b_valid/b_resp
// stable until the matching ready is seen.
//
// Timing: an address handshake (reads) or W handshake (writes) at edge T
// makes r_valid/b_valid visible from edge T+LATENCY. The counter loads
// LATENCY-1 on entry to a WAIT state and the response state is entered when
// it has reached 0.
// -----------------------------------------------------------------------------
module dram_axi_responder
    import dram_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [31:0]           ar_addr,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    input  logic [1:0]            ar_len,
    input  logic [1:0]            ar_size,
    input  logic [1:0]            ar_burst,

    output logic [LINE_BITS-1:0]  r_data,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic                  r_last,
    output logic                  r_resp,

    input  logic [31:0]           aw_addr,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [1:0]            aw_len,
    input  logic [1:0]            aw_size,
    input  logic [1:0]            aw_burst,

    input  logic [LINE_BITS-1:0]  w_data,
    input  logic [LINE_BYTES-1:0] w_strb,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic                  w_last,

    output logic                  b_valid,
    input  logic                  b_ready,
    output logic                  b_resp,

    output logic [2:0]            dbg_state
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    dram_state_e           state_q, state_d;
    logic [7:0]            cnt_q;
    logic                  prio_rd_q;   // 1 = read wins a tie
    logic                  err_q;
    logic [IDX_W-1:0]      idx_q;
    logic [LINE_BITS-1:0]  wdata_q;
    logic [LINE_BYTES-1:0] wstrb_q;
    logic [LINE_BITS-1:0]  r_data_q;
    logic                  r_resp_q;
    logic                  b_resp_q;

    logic                  grant_rd, grant_wr;
    logic                  w_fire, rd_done, wr_done;

    logic                  mem_rd_en, mem_wr_en;
    logic [IDX_W-1:0]      mem_rd_addr;
    logic [LINE_BITS-1:0]  mem_rd_data, mem_wr_data;

    // Size, burst and last carry no information for single-beat line traffic.
    logic unused_inputs;
    assign unused_inputs = ^{ar_size, ar_burst, aw_size, aw_burst, w_last};

    // ------------------------------------------------------------------
    // Arbiter and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        state_d  = state_q;

        // No grant while reset is asserted so nothing is accepted and lost.
        if ((state_q == IDLE) && !reset) begin
            if (ar_valid && (!aw_valid || prio_rd_q)) begin
                grant_rd = 1'b1;
            end else if (aw_valid) begin
                grant_wr = 1'b1;
            end
        end

        w_fire  = (state_q == WR_DATA) && w_valid;
        rd_done = (state_q == RD_WAIT) && (cnt_q == 8'd0);
        wr_done = (state_q == WR_WAIT) && (cnt_q == 8'd0);

        case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    state_d = RD_WAIT;
                end else if (grant_wr) begin
                    state_d = WR_DATA;
                end
            end
            RD_WAIT: if (rd_done) state_d = RD_RESP;
            RD_RESP: if (r_ready) state_d = IDLE;
            WR_DATA: if (w_valid) state_d = WR_WAIT;
            WR_WAIT: if (wr_done) state_d = WR_RESP;
            WR_RESP: if (b_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage access
    // ------------------------------------------------------------------
    // Reads are issued at the AR grant so the line is already registered
    // in the memory output when RD_WAIT starts; this is what makes
    // LATENCY = 1 possible. For writes the old line is fetched at the W
    // handshake, and the merged line is written on the final WR_WAIT
    // edge, the same edge that raises b_valid. Committing as late as
    // possible means a reset anywhere inside WR_WAIT leaves the array
    // untouched.
    assign mem_rd_en   = grant_rd || w_fire;
    assign mem_rd_addr = grant_rd ? ar_addr[OFFSET_BITS +: IDX_W] : idx_q;
    assign mem_wr_en   = wr_done && !err_q && !reset;
    assign mem_wr_data = merge_line(mem_rd_data, wdata_q, wstrb_q);

    memDP #(
        .WIDTH     (LINE_BITS),
        .DEPTH     (DEPTH),
        .BYPASS_EN (0)
    ) u_mem (
        .clock   (clock),
        .wr_en   (mem_wr_en),
        .wr_addr (idx_q),
        .wr_data (mem_wr_data),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_data)
    );

    // ------------------------------------------------------------------
    // State, counter, request attributes and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            prio_rd_q <= 1'b1;
            err_q     <= 1'b0;
            idx_q     <= '0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
            b_resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;

            if (grant_rd) begin
                idx_q <= ar_addr[OFFSET_BITS +: IDX_W];
                err_q <= req_error(ar_addr, ar_len, DEPTH);
            end else if (grant_wr) begin
                idx_q <= aw_addr[OFFSET_BITS +: IDX_W];
                err_q <= req_error(aw_addr, aw_len, DEPTH);
            end

            // Toggle on every grant so contending channels alternate.
            if (grant_rd || grant_wr) begin
                prio_rd_q <= ~prio_rd_q;
            end

            if (grant_rd || w_fire) begin
                cnt_q <= CNT_LOAD;
            end else if (((state_q == RD_WAIT) || (state_q == WR_WAIT)) && (cnt_q != 8'd0)) begin
                cnt_q <= cnt_q - 8'd1;
            end

            if (rd_done) begin
                r_data_q <= err_q ? '0 : mem_rd_data;
                r_resp_q <= err_q ? RESP_ERR : RESP_OKAY;
            end

            if (wr_done) begin
                b_resp_q <= err_q ? RESP_ERR : RESP_OKAY;
            end
        end
    end

    // Write payload capture; consumed only inside the same transaction.
    always_ff @(posedge clock) begin
        if (w_fire) begin
            wdata_q <= w_data;
            wstrb_q <= w_strb;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ar_ready  = grant_rd;
    assign aw_ready  = grant_wr;
    assign w_ready   = (state_q == WR_DATA);
    assign r_valid   = (state_q == RD_RESP);
    assign r_last    = r_valid;
    assign r_data    = r_data_q;
    assign r_resp    = r_resp_q;
    assign b_valid   = (state_q == WR_RESP);
    assign b_resp    = b_resp_q;
    assign dbg_state = state_q;

endmodule
